// File: rtl/reaction_game_ctrl_pkg.sv
// Shared types and constants for the reaction game sequencer and its display decoder.
package reaction_game_ctrl_pkg;

    localparam int unsigned MIN_DELAY_MS = 1000;
    localparam int unsigned RAND_BITS    = 11;
    localparam int unsigned MAX_MS       = 9999;
    localparam int unsigned FOUL_HOLD_MS = 2000;

    localparam int unsigned NUM_W   = 14;
    localparam int unsigned DELAY_W = 12;
    localparam int unsigned FOUL_W  = 11;
    localparam int unsigned LFSR_W  = 16;

    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_GO   = 3'd2,
        ST_DONE = 3'd3,
        ST_FOUL = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        DISP_NUM  = 2'd0,
        DISP_DASH = 2'd1,
        DISP_ERR  = 2'd2
    } disp_mode_e;

    // Pre-GO delay: fixed part plus the random low bits of the LFSR.
    function automatic logic [DELAY_W-1:0] arm_delay(input logic [RAND_BITS-1:0] rnd);
        return DELAY_W'(MIN_DELAY_MS) + DELAY_W'(rnd);
    endfunction

endpackage

// File: rtl/reaction_game_ctrl_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1; never reaches all-zero.
module reaction_game_ctrl_lfsr16
    import reaction_game_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    output logic [RAND_BITS-1:0] rand_o
);

    logic [LFSR_W-1:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign rand_o = lfsr_q[RAND_BITS-1:0];

endmodule

// File: rtl/reaction_game_ctrl.sv
// Reaction game sequencer: arm, random delay, GO, time the press in ms, show result/best.
module reaction_game_ctrl
    import reaction_game_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_1ms,
    input  logic             btn_start,
    input  logic             btn_react,
    output logic [NUM_W-1:0] number,
    output logic [1:0]       disp_mode,
    output logic             led_go,
    output logic             timeout
);

    state_e               state_q, state_d;
    logic [DELAY_W-1:0]   delay_q, delay_d;
    logic [NUM_W-1:0]     ms_q, ms_d;
    logic [NUM_W-1:0]     result_q, result_d;
    logic [NUM_W-1:0]     best_q, best_d;
    logic [NUM_W-1:0]     number_q, number_d;
    logic [FOUL_W-1:0]    foul_q, foul_d;
    disp_mode_e           disp_q, disp_d;
    logic                 led_go_q, led_go_d;
    logic                 timeout_q, timeout_d;
    logic [RAND_BITS-1:0] rnd;

    reaction_game_ctrl_lfsr16 u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .rand_o (rnd)
    );

    always_comb begin
        state_d   = state_q;
        delay_d   = delay_q;
        ms_d      = ms_q;
        result_d  = result_q;
        best_d    = best_q;
        foul_d    = foul_q;
        timeout_d = timeout_q;
        number_d  = '0;
        disp_d    = DISP_NUM;
        led_go_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (btn_start) begin
                    state_d = ST_ARM;
                    delay_d = arm_delay(rnd);
                end
            end
            ST_ARM: begin
                // An early press beats a same-cycle final tick.
                if (btn_react) begin
                    state_d = ST_FOUL;
                    foul_d  = FOUL_W'(FOUL_HOLD_MS);
                end else if (tick_1ms) begin
                    if (delay_q == DELAY_W'(1)) begin
                        state_d = ST_GO;
                        ms_d    = '0;
                    end else begin
                        delay_d = delay_q - DELAY_W'(1);
                    end
                end
            end
            ST_GO: begin
                // The press captures the count before any same-cycle tick.
                if (btn_react) begin
                    state_d  = ST_DONE;
                    result_d = ms_q;
                    if (ms_q < best_q) begin
                        best_d = ms_q;
                    end
                end else if (tick_1ms) begin
                    if (ms_q == NUM_W'(MAX_MS - 1)) begin
                        state_d   = ST_DONE;
                        result_d  = NUM_W'(MAX_MS);
                        timeout_d = 1'b1;
                    end else begin
                        ms_d = ms_q + NUM_W'(1);
                    end
                end
            end
            ST_DONE: begin
                if (btn_start) begin
                    state_d   = ST_ARM;
                    delay_d   = arm_delay(rnd);
                    timeout_d = 1'b0;
                end
            end
            ST_FOUL: begin
                if (tick_1ms) begin
                    foul_d = foul_q - FOUL_W'(1);
                    if (foul_q == FOUL_W'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Display outputs follow the state being entered so they register on the same edge.
        case (state_d)
            ST_IDLE: number_d = best_d;
            ST_ARM:  disp_d   = DISP_DASH;
            ST_GO: begin
                number_d = ms_d;
                led_go_d = 1'b1;
            end
            ST_DONE: number_d = result_d;
            ST_FOUL: disp_d   = DISP_ERR;
            default: number_d = best_d;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            delay_q   <= '0;
            ms_q      <= '0;
            result_q  <= '0;
            best_q    <= NUM_W'(MAX_MS);
            foul_q    <= '0;
            timeout_q <= 1'b0;
            number_q  <= NUM_W'(MAX_MS);
            disp_q    <= DISP_NUM;
            led_go_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            delay_q   <= delay_d;
            ms_q      <= ms_d;
            result_q  <= result_d;
            best_q    <= best_d;
            foul_q    <= foul_d;
            timeout_q <= timeout_d;
            number_q  <= number_d;
            disp_q    <= disp_d;
            led_go_q  <= led_go_d;
        end
    end

    assign number    = number_q;
    assign disp_mode = 2'(disp_q);
    assign led_go    = led_go_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Directed/randomized bench for reaction_game_ctrl against a round-level reference model.
module tb_reaction_game_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick_1ms;
    logic        btn_start;
    logic        btn_react;
    logic [13:0] number;
    logic [1:0]  disp_mode;
    logic        led_go;
    logic        timeout;

    int total = 0;
    int bad   = 0;
    int best_m;
    int d;
    int r;
    logic [15:0] lfsr_m;

    reaction_game_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .tick_1ms  (tick_1ms),
        .btn_start (btn_start),
        .btn_react (btn_react),
        .number    (number),
        .disp_mode (disp_mode),
        .led_go    (led_go),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    // Reference copy of the free-running random source (taps 16,14,13,11).
    always @(posedge clk or negedge rst) begin
        if (!rst) lfsr_m <= 16'hACE1;
        else      lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic t, input logic s, input logic rr);
        tick_1ms  = t;
        btn_start = s;
        btn_react = rr;
        @(posedge clk);
        @(negedge clk);
        tick_1ms  = 1'b0;
        btn_start = 1'b0;
        btn_react = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) step(1'b0, 1'b0, 1'b0);
            step(1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic start_round(output int dly);
        dly = 1000 + int'(lfsr_m[10:0]);
        step(1'b0, 1'b1, 1'b0);
        check("arm_disp", 32'(disp_mode), 1);
        check("arm_num", 32'(number), 0);
        check("arm_timeout", 32'(timeout), 0);
    endtask

    task automatic to_go(input int dly);
        ticks(dly - 1);
        check("arm_hold_led", 32'(led_go), 0);
        step(1'b0, 1'b1, 1'b0);
        check("arm_start_ignored", 32'(disp_mode), 1);
        step(1'b1, 1'b0, 1'b0);
        check("go_led", 32'(led_go), 1);
        check("go_disp", 32'(disp_mode), 0);
        check("go_num", 32'(number), 0);
    endtask

    task automatic play(input int n, input bit simul);
        int dl;
        start_round(dl);
        to_go(dl);
        ticks(n);
        check("go_live", 32'(number), 32'(n));
        step(1'b0, 1'b1, 1'b0);
        check("go_start_ignored", 32'(led_go), 1);
        if (simul) step(1'b1, 1'b0, 1'b1);
        else       step(1'b0, 1'b0, 1'b1);
        check("done_num", 32'(number), 32'(n));
        check("done_disp", 32'(disp_mode), 0);
        check("done_led", 32'(led_go), 0);
        check("done_timeout", 32'(timeout), 0);
        if (n < best_m) best_m = n;
        step(1'b1, 1'b0, 1'b1);
        check("done_react_ignored", 32'(number), 32'(n));
    endtask

    task automatic foul_round(input bit at_final, input int arm_ticks);
        int dl;
        start_round(dl);
        if (at_final) begin
            ticks(dl - 1);
            step(1'b1, 1'b0, 1'b1);
        end else begin
            ticks(arm_ticks);
            step(1'b0, 1'b0, 1'b1);
        end
        check("foul_disp", 32'(disp_mode), 2);
        check("foul_num", 32'(number), 0);
        check("foul_led", 32'(led_go), 0);
        step(1'b0, 1'b1, 1'b1);
        ticks(1999);
        check("foul_hold", 32'(disp_mode), 2);
        step(1'b1, 1'b0, 1'b0);
        check("idle_disp", 32'(disp_mode), 0);
        check("idle_best", 32'(number), 32'(best_m));
    endtask

    initial begin
        rst       = 1'b0;
        tick_1ms  = 1'b0;
        btn_start = 1'b0;
        btn_react = 1'b0;
        best_m    = 9999;
        repeat (3) @(negedge clk);
        check("rst_num", 32'(number), 9999);
        check("rst_disp", 32'(disp_mode), 0);
        check("rst_led", 32'(led_go), 0);
        check("rst_timeout", 32'(timeout), 0);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);

        // Reset in the middle of GO
        start_round(d);
        to_go(d);
        ticks(5);
        check("go_pre_reset", 32'(number), 5);
        rst = 1'b0;
        #1;
        check("midrst_num", 32'(number), 9999);
        check("midrst_disp", 32'(disp_mode), 0);
        check("midrst_led", 32'(led_go), 0);
        @(negedge clk);
        step(1'b1, 1'b1, 1'b1);
        rst = 1'b1;
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check("post_rst_num", 32'(number), 9999);
        check("post_rst_disp", 32'(disp_mode), 0);
        check("post_rst_led", 32'(led_go), 0);
        best_m = 9999;

        // Normal round, then false start revealing best in IDLE
        play(237, 1'b0);
        foul_round(1'b0, 500);

        // Timeout round: saturates, best untouched
        start_round(d);
        to_go(d);
        ticks(9998);
        check("to_pre_num", 32'(number), 9998);
        check("to_pre_timeout", 32'(timeout), 0);
        step(1'b1, 1'b0, 1'b0);
        check("to_num", 32'(number), 9999);
        check("to_timeout", 32'(timeout), 1);
        check("to_led", 32'(led_go), 0);
        step(1'b1, 1'b0, 1'b1);
        check("to_hold_num", 32'(number), 9999);
        check("to_hold_timeout", 32'(timeout), 1);

        // Simultaneous tick and react; final ARM tick with react
        play(41, 1'b1);
        best_m = 41;
        foul_round(1'b1, 0);

        // Best tracking across several rounds plus a random one
        play(300, 1'b0);
        play(180, 1'b0);
        play(250, 1'b0);
        r = int'($urandom_range(20, 400));
        play(r, ($urandom_range(0, 1) == 1));
        foul_round(1'b0, int'($urandom_range(1, 900)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
